// File: rtl/fx_master_if.sv
// fx bus interface: host command channel, read response channel and the
// broadcast fx strobe/address/data bus with the OR-combined slave read data.
interface fx_master_if #(
  parameter int ADDR_W = 16
);
  // Host command channel
  logic              cmd_vld;
  logic              cmd_rdy;
  logic              cmd_wr;
  logic [ADDR_W-1:0] cmd_addr;
  logic [7:0]        cmd_data;

  // Read response channel
  logic              rsp_vld;
  logic              rsp_rdy;
  logic [7:0]        rsp_data;

  // fx slave bus
  logic              fx_wr;
  logic [ADDR_W-1:0] fx_waddr;
  logic [7:0]        fx_data;
  logic              fx_rd;
  logic [ADDR_W-1:0] fx_raddr;
  logic [7:0]        fx_q;

  // Initiator view (fx_master)
  modport master (
    input  cmd_vld, cmd_wr, cmd_addr, cmd_data,
    output cmd_rdy,
    output rsp_vld, rsp_data,
    input  rsp_rdy,
    output fx_wr, fx_waddr, fx_data, fx_rd, fx_raddr,
    input  fx_q
  );

  // Surrounding view: host command decoder plus the fx slaves
  modport slave (
    output cmd_vld, cmd_wr, cmd_addr, cmd_data,
    input  cmd_rdy,
    input  rsp_vld, rsp_data,
    output rsp_rdy,
    input  fx_wr, fx_waddr, fx_data, fx_rd, fx_raddr,
    output fx_q
  );
endinterface

// File: rtl/fx_master.sv
// fx_master: initiator of the fx register bus. Accepts one single-beat
// read/write command at a time, pulses the matching fx strobe for one cycle,
// and for reads samples the OR-combined fx_q after RD_LAT cycles and hands it
// back over a valid/ready response channel. All outputs are registered.
module fx_master #(
  parameter int ADDR_W = 16,
  parameter int RD_LAT = 2   // 1..15, not checked
) (
  input  logic          clk_sys,
  input  logic          rst_n,
  fx_master_if.master   bus,
  output logic          busy
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] WR   = 3'd1;
  localparam logic [2:0] RD   = 3'd2;
  localparam logic [2:0] WAIT = 3'd3;
  localparam logic [2:0] RSP  = 3'd4;

  // Counter preload: the WAIT state lasts RD_LAT cycles, the last one at 0.
  localparam logic [3:0] LAT_LOAD = 4'(RD_LAT - 1);

  logic [2:0]        state;
  logic [2:0]        state_nxt;
  logic [3:0]        lat_cnt;
  logic              accept;

  logic              cmd_rdy_q;
  logic              rsp_vld_q;
  logic [7:0]        rsp_data_q;
  logic              fx_wr_q;
  logic              fx_rd_q;
  logic [ADDR_W-1:0] fx_waddr_q;
  logic [ADDR_W-1:0] fx_raddr_q;
  logic [7:0]        fx_data_q;

  // cmd_rdy_q mirrors state==IDLE, so this is the handshake in IDLE.
  assign accept = bus.cmd_vld & cmd_rdy_q;

  // Next-state decode.
  always_comb begin
    // NOTE: default first so every path assigns state_nxt; no latch.
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = bus.cmd_wr ? WR : RD;
      WR:      state_nxt = IDLE;
      RD:      state_nxt = WAIT;
      WAIT:    if (lat_cnt == 4'd0) state_nxt = RSP;
      RSP:     if (rsp_vld_q && bus.rsp_rdy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register and status/strobe outputs, registered from the next state
  // so each output is true exactly for the cycles spent in its state.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignment only.
      state     <= IDLE;
      cmd_rdy_q <= 1'b1;
      busy      <= 1'b0;
      fx_wr_q   <= 1'b0;
      fx_rd_q   <= 1'b0;
      rsp_vld_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      cmd_rdy_q <= (state_nxt == IDLE);
      busy      <= (state_nxt != IDLE);
      fx_wr_q   <= (state_nxt == WR);
      fx_rd_q   <= (state_nxt == RD);
      rsp_vld_q <= (state_nxt == RSP);
    end
  end

  // Command field capture: only on accept; values persist while idle.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      fx_waddr_q <= '0;
      fx_data_q  <= '0;
      fx_raddr_q <= '0;
    end else if (state == IDLE && accept) begin
      if (bus.cmd_wr) begin
        fx_waddr_q <= bus.cmd_addr;
        fx_data_q  <= bus.cmd_data;
      end else begin
        fx_raddr_q <= bus.cmd_addr;
      end
    end
  end

  // Read latency counter: loaded during the fx_rd cycle, counts down in WAIT.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      lat_cnt <= 4'd0;
    end else if (state == RD) begin
      lat_cnt <= LAT_LOAD;
    end else if (state == WAIT && lat_cnt != 4'd0) begin
      lat_cnt <= lat_cnt - 4'd1;
    end
  end

  // Response data: fx_q is sampled only on the final WAIT edge, then held.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data_q <= 8'd0;
    end else if (state == WAIT && lat_cnt == 4'd0) begin
      rsp_data_q <= bus.fx_q;
    end
  end

  assign bus.cmd_rdy  = cmd_rdy_q;
  assign bus.rsp_vld  = rsp_vld_q;
  assign bus.rsp_data = rsp_data_q;
  assign bus.fx_wr    = fx_wr_q;
  assign bus.fx_rd    = fx_rd_q;
  assign bus.fx_waddr = fx_waddr_q;
  assign bus.fx_raddr = fx_raddr_q;
  assign bus.fx_data  = fx_data_q;

endmodule

// File: tb/tb_fx_master.sv
// Directed bench for fx_master: three instances (RD_LAT = 2, 1, 15) on one
// clock; expected values are hand-derived cycle by cycle from the accept edge.
module tb_fx_master;

  logic clk_sys = 1'b0;
  logic rst_n;
  logic busy2, busy1, busy15;

  int tests = 0;
  int fails = 0;

  always #5 clk_sys = ~clk_sys;

  fx_master_if #(.ADDR_W(16)) bus2  ();
  fx_master_if #(.ADDR_W(16)) bus1  ();
  fx_master_if #(.ADDR_W(16)) bus15 ();

  fx_master #(.ADDR_W(16), .RD_LAT(2)) dut2 (
    .clk_sys(clk_sys), .rst_n(rst_n), .bus(bus2), .busy(busy2)
  );
  fx_master #(.ADDR_W(16), .RD_LAT(1)) dut1 (
    .clk_sys(clk_sys), .rst_n(rst_n), .bus(bus1), .busy(busy1)
  );
  fx_master #(.ADDR_W(16), .RD_LAT(15)) dut15 (
    .clk_sys(clk_sys), .rst_n(rst_n), .bus(bus15), .busy(busy15)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; samples land 1 time unit later.
  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // Strobe/response snapshot of the RD_LAT=2 instance, plus strobe exclusivity.
  task automatic strobes2(input string tag, input logic wr, input logic rd, input logic rv);
    check({tag, " fx_wr"},   32'(bus2.fx_wr),   32'(wr));
    check({tag, " fx_rd"},   32'(bus2.fx_rd),   32'(rd));
    check({tag, " rsp_vld"}, 32'(bus2.rsp_vld), 32'(rv));
    check({tag, " excl"},    32'(bus2.fx_wr & bus2.fx_rd), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus2.cmd_vld = 0;  bus2.cmd_wr = 0;  bus2.cmd_addr = 0;  bus2.cmd_data = 0;
    bus2.rsp_rdy = 0;  bus2.fx_q = 8'hFF;
    bus1.cmd_vld = 0;  bus1.cmd_wr = 0;  bus1.cmd_addr = 0;  bus1.cmd_data = 0;
    bus1.rsp_rdy = 0;  bus1.fx_q = 8'hFF;
    bus15.cmd_vld = 0; bus15.cmd_wr = 0; bus15.cmd_addr = 0; bus15.cmd_data = 0;
    bus15.rsp_rdy = 0; bus15.fx_q = 8'hFF;

    // ---- Reset state
    repeat (3) tick();
    check("rst cmd_rdy",  32'(bus2.cmd_rdy),  1);
    check("rst busy",     32'(busy2),         0);
    strobes2("rst", 0, 0, 0);
    check("rst waddr",    32'(bus2.fx_waddr), 0);
    check("rst raddr",    32'(bus2.fx_raddr), 0);
    check("rst data",     32'(bus2.fx_data),  0);
    check("rst rsp_data", 32'(bus2.rsp_data), 0);
    rst_n = 1'b1;
    tick();
    check("post-rst cmd_rdy", 32'(bus2.cmd_rdy), 1);

    // ---- 1. Single write
    bus2.cmd_vld = 1; bus2.cmd_wr = 1; bus2.cmd_addr = 16'h0012; bus2.cmd_data = 8'hA5;
    tick();                                   // edge T -> cycle T+1
    strobes2("wr T+1", 1, 0, 0);
    check("wr T+1 waddr",   32'(bus2.fx_waddr), 'h0012);
    check("wr T+1 data",    32'(bus2.fx_data),  'hA5);
    check("wr T+1 cmd_rdy", 32'(bus2.cmd_rdy),  0);
    check("wr T+1 busy",    32'(busy2),         1);
    bus2.cmd_vld = 0;
    tick();                                   // cycle T+2
    strobes2("wr T+2", 0, 0, 0);
    check("wr T+2 cmd_rdy", 32'(bus2.cmd_rdy),  1);
    check("wr T+2 busy",    32'(busy2),         0);
    check("wr T+2 waddr",   32'(bus2.fx_waddr), 'h0012);
    tick();
    strobes2("wr T+3", 0, 0, 0);

    // ---- 2/3. Read RD_LAT=2 with response backpressure
    bus2.cmd_vld = 1; bus2.cmd_wr = 0; bus2.cmd_addr = 16'h0040; bus2.rsp_rdy = 0;
    tick();                                   // cycle T+1
    strobes2("rd T+1", 0, 1, 0);
    check("rd T+1 raddr", 32'(bus2.fx_raddr), 'h0040);
    bus2.cmd_vld = 0; bus2.cmd_addr = 16'hDEAD;
    tick();                                   // cycle T+2
    strobes2("rd T+2", 0, 0, 0);
    check("rd T+2 raddr", 32'(bus2.fx_raddr), 'h0040);
    tick();                                   // cycle T+3: slave drives data
    bus2.fx_q = 8'h3C;
    strobes2("rd T+3", 0, 0, 0);
    tick();                                   // cycle T+4
    bus2.fx_q = 8'hFF;
    strobes2("rd T+4", 0, 0, 1);
    check("rd T+4 rsp_data", 32'(bus2.rsp_data), 'h3C);
    for (int i = 0; i < 5; i++) begin
      tick();
      bus2.fx_q = 8'(8'h10 + i);
      strobes2("bp hold", 0, 0, 1);
      check("bp rsp_data", 32'(bus2.rsp_data), 'h3C);
      check("bp cmd_rdy",  32'(bus2.cmd_rdy),  0);
      check("bp busy",     32'(busy2),         1);
    end
    bus2.fx_q = 8'hFF;
    bus2.rsp_rdy = 1;
    tick();
    strobes2("bp release", 0, 0, 0);
    check("bp release cmd_rdy", 32'(bus2.cmd_rdy), 1);
    check("bp release busy",    32'(busy2),        0);

    // ---- 4. Back-to-back write, write, read with cmd_vld held high
    bus2.cmd_vld = 1; bus2.cmd_wr = 1; bus2.cmd_addr = 16'h00A1; bus2.cmd_data = 8'h11;
    tick();                                   // T+1
    strobes2("b2b T+1", 1, 0, 0);
    check("b2b T+1 waddr", 32'(bus2.fx_waddr), 'h00A1);
    check("b2b T+1 data",  32'(bus2.fx_data),  'h11);
    bus2.cmd_addr = 16'h00A2; bus2.cmd_data = 8'h22;
    tick();                                   // T+2
    strobes2("b2b T+2", 0, 0, 0);
    check("b2b T+2 cmd_rdy", 32'(bus2.cmd_rdy), 1);
    tick();                                   // T+3
    strobes2("b2b T+3", 1, 0, 0);
    check("b2b T+3 waddr", 32'(bus2.fx_waddr), 'h00A2);
    check("b2b T+3 data",  32'(bus2.fx_data),  'h22);
    bus2.cmd_wr = 0; bus2.cmd_addr = 16'h00A3;
    tick();                                   // T+4
    strobes2("b2b T+4", 0, 0, 0);
    check("b2b T+4 waddr held", 32'(bus2.fx_waddr), 'h00A2);
    tick();                                   // T+5
    strobes2("b2b T+5", 0, 1, 0);
    check("b2b T+5 raddr", 32'(bus2.fx_raddr), 'h00A3);
    bus2.cmd_vld = 0;
    tick();                                   // T+6
    strobes2("b2b T+6", 0, 0, 0);
    tick();                                   // T+7
    bus2.fx_q = 8'h5A;
    strobes2("b2b T+7", 0, 0, 0);
    tick();                                   // T+8
    bus2.fx_q = 8'hFF;
    strobes2("b2b T+8", 0, 0, 1);
    check("b2b T+8 rsp_data", 32'(bus2.rsp_data), 'h5A);
    tick();                                   // T+9
    strobes2("b2b T+9", 0, 0, 0);
    check("b2b T+9 cmd_rdy", 32'(bus2.cmd_rdy), 1);

    // ---- 5a. RD_LAT=1
    bus1.rsp_rdy = 1;
    bus1.cmd_vld = 1; bus1.cmd_wr = 0; bus1.cmd_addr = 16'h0111;
    tick();                                   // T+1
    check("lat1 T+1 fx_rd", 32'(bus1.fx_rd),    1);
    check("lat1 T+1 raddr", 32'(bus1.fx_raddr), 'h0111);
    bus1.cmd_vld = 0;
    tick();                                   // T+2: capture cycle
    bus1.fx_q = 8'h81;
    check("lat1 T+2 rsp_vld", 32'(bus1.rsp_vld), 0);
    tick();                                   // T+3
    bus1.fx_q = 8'hFF;
    check("lat1 T+3 rsp_vld",  32'(bus1.rsp_vld),  1);
    check("lat1 T+3 rsp_data", 32'(bus1.rsp_data), 'h81);
    tick();
    check("lat1 T+4 rsp_vld", 32'(bus1.rsp_vld), 0);
    check("lat1 T+4 cmd_rdy", 32'(bus1.cmd_rdy), 1);

    // ---- 5b. RD_LAT=15
    bus15.rsp_rdy = 1;
    bus15.cmd_vld = 1; bus15.cmd_wr = 0; bus15.cmd_addr = 16'h0F0F;
    tick();                                   // T+1
    check("lat15 T+1 fx_rd", 32'(bus15.fx_rd), 1);
    bus15.cmd_vld = 0;
    for (int c = 2; c <= 17; c++) begin
      tick();                                 // cycle T+c
      bus15.fx_q = (c == 16) ? 8'hC3 : 8'hFF;
      check("lat15 rsp_vld", 32'(bus15.rsp_vld), (c == 17) ? 1 : 0);
      check("lat15 fx_rd",   32'(bus15.fx_rd),   0);
    end
    check("lat15 rsp_data", 32'(bus15.rsp_data), 'hC3);
    tick();
    check("lat15 done cmd_rdy", 32'(bus15.cmd_rdy), 1);
    check("lat15 done rsp_vld", 32'(bus15.rsp_vld), 0);

    // ---- 6. Async reset in WAIT
    bus2.cmd_vld = 1; bus2.cmd_wr = 0; bus2.cmd_addr = 16'h0077;
    tick();                                   // T+1
    strobes2("ar T+1", 0, 1, 0);
    bus2.cmd_vld = 0;
    tick();                                   // T+2, WAIT
    check("ar WAIT busy", 32'(busy2), 1);
    #3 rst_n = 1'b0;
    #1;
    check("ar cmd_rdy",  32'(bus2.cmd_rdy),  1);
    check("ar busy",     32'(busy2),         0);
    strobes2("ar async", 0, 0, 0);
    check("ar raddr",    32'(bus2.fx_raddr), 0);
    check("ar waddr",    32'(bus2.fx_waddr), 0);
    check("ar data",     32'(bus2.fx_data),  0);
    check("ar rsp_data", 32'(bus2.rsp_data), 0);
    #2 rst_n = 1'b1;
    bus2.fx_q = 8'h99;
    for (int i = 0; i < 6; i++) begin
      tick();
      strobes2("ar quiet", 0, 0, 0);
      check("ar quiet cmd_rdy", 32'(bus2.cmd_rdy), 1);
    end
    bus2.cmd_vld = 1; bus2.cmd_wr = 1; bus2.cmd_addr = 16'h0005; bus2.cmd_data = 8'h06;
    tick();
    strobes2("ar new wr", 1, 0, 0);
    check("ar new waddr", 32'(bus2.fx_waddr), 'h0005);
    bus2.cmd_vld = 0;
    tick();
    check("ar new cmd_rdy", 32'(bus2.cmd_rdy), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fx_master.md
Name: fx_master

Overview:
- Initiator end of the fx register bus.
- Takes single-beat read/write commands from the host command path over a valid/ready handshake.
- Drives the fx write/read strobes, addresses and write data to all fx slaves.
- Samples the OR-combined slave read data `fx_q` after a fixed read latency and returns it over a valid/ready response channel.
- Sits between the host command decoder and the slave blocks: syn, ad1-3, dsp, ep, commu, pack.

Parameters:
- ADDR_W, 16, fx address width.
- RD_LAT, 2, cycles from the `fx_rd` strobe to valid `fx_q`; legal range 1..15.

Ports:
- clk_sys  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_vld  in  1  command valid.
- cmd_rdy  out  1  command ready.
- cmd_wr  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  command address.
- cmd_data  in  8  write data; ignored for reads.
- rsp_vld  out  1  read response valid.
- rsp_rdy  in  1  read response accepted.
- rsp_data  out  8  read data.
- fx_wr  out  1  one-cycle write strobe.
- fx_waddr  out  ADDR_W  write address.
- fx_data  out  8  write data.
- fx_rd  out  1  one-cycle read strobe.
- fx_raddr  out  ADDR_W  read address.
- fx_q  in  8  OR-combined slave read data.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE.
  - `cmd_rdy`=1, `rsp_vld`=0, `fx_wr`=0, `fx_rd`=0, `busy`=0.
  - `fx_waddr`, `fx_raddr`, `fx_data`, `rsp_data` = 0.
  - Latency counter = 0.
- All outputs are registered. `cmd_rdy` = (state==IDLE); `busy` = !cmd_rdy.
- Accept happens when `cmd_vld` & `cmd_rdy` on edge T. Command fields are captured only on accept.
- States:
  - IDLE: on accept with `cmd_wr`=1 go to WR; on accept with `cmd_wr`=0 go to RD.
  - WR (cycle T+1): `fx_wr`=1, `fx_waddr`=`cmd_addr`, `fx_data`=`cmd_data`. Go to IDLE; `cmd_rdy`=1 at T+2. Writes produce no response.
  - RD (cycle T+1): `fx_rd`=1, `fx_raddr`=`cmd_addr`. Load the counter with RD_LAT-1 and go to WAIT.
  - WAIT: `fx_rd`=0 and `fx_raddr` held stable. Decrement the counter each cycle. At the edge ending cycle T+1+RD_LAT, capture `fx_q` into `rsp_data` and go to RSP. For RD_LAT=1 the capture is on the first WAIT edge.
  - RSP: `rsp_vld`=1 starting at cycle T+2+RD_LAT. `rsp_vld` and `rsp_data` are held until `rsp_vld` & `rsp_rdy`; then `rsp_vld`=0 and go to IDLE on the next cycle.
- Strobe rules:
  - `fx_wr` and `fx_rd` are never high together.
  - Each is high for exactly one cycle per command.
  - At most one transaction is outstanding.
- `fx_waddr`, `fx_data` and `fx_raddr` keep their last values when idle; they do not return to 0.
- `fx_q` is sampled only on the capture edge. Changes on `fx_q` at any other time are ignored.
- `rsp_rdy` asserted before `rsp_vld` is ignored. `rsp_rdy` held high continuously gives a one-cycle `rsp_vld` pulse.
- `cmd_vld` while not ready: the command is not consumed. The host holds `cmd_vld` and fields stable until accepted.
- Back-to-back throughput:
  - Writes: one every 2 cycles.
  - Reads: one every RD_LAT+3 cycles with `rsp_rdy` high.
- Reset mid-transaction: the transaction is abandoned and all outputs go to reset values immediately (async). A captured or pending response is lost. No strobe is emitted after release until a new accept.
- Counter width is 4 bits. RD_LAT outside 1..15 is unsupported; the RTL does not check it.

Test Plan:
1. Write: accept `cmd_wr`=1, `cmd_addr`=16'h0012, `cmd_data`=8'hA5 at edge T -> `fx_wr`=1 for only cycle T+1 with `fx_waddr`=0012, `fx_data`=A5; `cmd_rdy`=1 at T+2; `rsp_vld` never asserts.
2. Read, RD_LAT=2: accept read 16'h0040 at T; slave model drives `fx_q`=8'h3C exactly in cycle T+3 and 8'hFF otherwise -> `fx_rd` pulse at T+1 with `fx_raddr`=0040; `rsp_vld`=1 at T+4 with `rsp_data`=3C.
3. Response backpressure: in scenario 2 hold `rsp_rdy`=0 for 5 cycles after `rsp_vld` rises -> `rsp_vld` and `rsp_data`=3C stable throughout, `cmd_rdy`=0, `busy`=1, no further strobes; release `rsp_rdy` -> back to IDLE the next cycle.
4. Back-to-back with `cmd_vld` held high: write, write, read, with `rsp_rdy`=1 -> `fx_wr` pulses at T+1 and T+3; `fx_rd` pulse at T+5; never both strobes high; read response at T+8 for RD_LAT=2.
5. Parameter sweep RD_LAT=1 and RD_LAT=15 -> `rsp_vld` at T+3 and T+17 respectively, with the captured `fx_q` equal to the value driven at cycle T+1+RD_LAT.
6. Async reset: assert `rst_n`=0 during WAIT, mid-cycle -> outputs go to reset values immediately without waiting for a clock edge; after release, no `rsp_vld` and no strobe until a new command is accepted.
